// File: rtl/decode_stage_pipe_if.sv
// Decode stage bus: fetch/writeback/execute-control inputs plus the registered ID/EX output bank.
// master = surrounding pipeline (fetch, execute, writeback); slave = decode_stage_pipe.
interface decode_stage_pipe_if #(
  parameter int XLEN   = 16,
  parameter int REG_AW = 4
);
  logic              in_valid;
  logic [XLEN-1:0]   pc_in;
  logic [XLEN-1:0]   IPCP2;
  logic [15:0]       ir_in;
  logic              stall_in;
  logic              flush_in;
  logic              rf_write;
  logic [REG_AW-1:0] loadAddr;
  logic [XLEN-1:0]   loadData;

  logic              out_valid, RegWrite, ALUSrc, MemWrite, MemRead, RegStore;
  logic [2:0]        ALUOp;
  logic [XLEN-1:0]   OPCP2, Arg1, Arg2, Arg3, Imm, new_pc;
  logic [REG_AW-1:0] Rs1, Rs2, Rd;
  logic              jump, stall_out;

  modport master (
    output in_valid, pc_in, IPCP2, ir_in, stall_in, flush_in, rf_write, loadAddr, loadData,
    input  out_valid, RegWrite, ALUSrc, MemWrite, MemRead, RegStore, ALUOp,
           OPCP2, Arg1, Arg2, Arg3, Imm, new_pc, Rs1, Rs2, Rd, jump, stall_out
  );

  modport slave (
    input  in_valid, pc_in, IPCP2, ir_in, stall_in, flush_in, rf_write, loadAddr, loadData,
    output out_valid, RegWrite, ALUSrc, MemWrite, MemRead, RegStore, ALUOp,
           OPCP2, Arg1, Arg2, Arg3, Imm, new_pc, Rs1, Rs2, Rd, jump, stall_out
  );
endinterface

// File: rtl/decode_stage_pipe.sv
// ID stage: 16-bit decode, register file, branch/jump resolve, load-use interlock, ID/EX bank.
// Optional write-first register file bypass is enabled by defining DECODE_FWD_EN.
module decode_stage_pipe #(
  parameter int XLEN   = 16,
  parameter int REG_AW = 4
) (
  input  logic               clk,
  input  logic               reset,
  decode_stage_pipe_if.slave bus
);
  localparam int NREG = 2**REG_AW;
`ifdef DECODE_FWD_EN
  localparam bit FWD_EN = 1'b1;
`else
  localparam bit FWD_EN = 1'b0;
`endif

  typedef struct packed {
    logic              valid;
    logic              reg_write;
    logic              alu_src;
    logic              mem_write;
    logic              mem_read;
    logic              reg_store;
    logic [2:0]        alu_op;
    logic [XLEN-1:0]   opcp2;
    logic [XLEN-1:0]   arg1;
    logic [XLEN-1:0]   arg2;
    logic [XLEN-1:0]   arg3;
    logic [XLEN-1:0]   imm;
    logic [XLEN-1:0]   new_pc;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic [REG_AW-1:0] rd;
    logic              jump;
  } bank_t;

  bank_t                     bank_q, bank_d, dec;
  logic [NREG-1:0][XLEN-1:0] rf_q, rf_d;
  logic [3:0]                op;
  logic [REG_AW-1:0]         rd_i, rs1_i, rs2_i;
  logic [XLEN-1:0]           imm4, imm8, br_tgt, jal_tgt;
  logic                      hazard;

  // r0 is hardwired to zero, so it masks any bypass as well.
  function automatic logic [XLEN-1:0] rf_read(
    input logic [NREG-1:0][XLEN-1:0] rf,
    input logic [REG_AW-1:0]         idx,
    input logic                      we,
    input logic [REG_AW-1:0]         wa,
    input logic [XLEN-1:0]           wd
  );
    logic [XLEN-1:0] v;
    v = rf[idx];
    if (FWD_EN && we && (wa == idx)) v = wd;
    if (idx == '0) v = '0;
    return v;
  endfunction

  always_comb begin
    op      = bus.ir_in[15:12];
    rd_i    = bus.ir_in[8 +: REG_AW];
    rs1_i   = bus.ir_in[4 +: REG_AW];
    rs2_i   = bus.ir_in[0 +: REG_AW];
    imm4    = {{(XLEN-4){bus.ir_in[3]}}, bus.ir_in[3:0]};
    imm8    = {{(XLEN-8){bus.ir_in[7]}}, bus.ir_in[7:0]};
    br_tgt  = bus.pc_in + (imm4 << 1);
    jal_tgt = bus.pc_in + (imm8 << 1);

    dec        = '0;
    dec.valid  = 1'b1;
    dec.opcp2  = bus.IPCP2;
    dec.rs1    = rs1_i;
    dec.rs2    = rs2_i;
    dec.rd     = rd_i;
    dec.arg1   = rf_read(rf_q, rs1_i, bus.rf_write, bus.loadAddr, bus.loadData);
    dec.arg2   = rf_read(rf_q, rs2_i, bus.rf_write, bus.loadAddr, bus.loadData);
    dec.arg3   = rf_read(rf_q, rd_i,  bus.rf_write, bus.loadAddr, bus.loadData);
    dec.new_pc = bus.pc_in;

    case (op)
      4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7: begin
        dec.reg_write = 1'b1;
        dec.alu_op    = op[2:0];
      end
      4'h8: begin
        dec.reg_write = 1'b1; dec.alu_src = 1'b1; dec.alu_op = 3'd1; dec.imm = imm4;
      end
      4'h9: begin
        dec.reg_write = 1'b1; dec.mem_read = 1'b1; dec.alu_src = 1'b1;
        dec.alu_op    = 3'd1; dec.imm = imm4;
      end
      4'hA: begin
        dec.mem_write = 1'b1; dec.reg_store = 1'b1; dec.alu_src = 1'b1;
        dec.alu_op    = 3'd1; dec.imm = imm4;
      end
      4'hB: if (dec.arg3 == dec.arg1) begin dec.jump = 1'b1; dec.new_pc = br_tgt; end
      4'hC: if (dec.arg3 != dec.arg1) begin dec.jump = 1'b1; dec.new_pc = br_tgt; end
      4'hD: begin dec.reg_write = 1'b1; dec.jump = 1'b1; dec.new_pc = jal_tgt; end
      4'hE: begin dec.jump = 1'b1; dec.new_pc = dec.arg1; end
      4'hF: begin
        dec.reg_write = 1'b1; dec.alu_src = 1'b1;
        dec.imm       = {bus.ir_in[7:0], {(XLEN-8){1'b0}}};
      end
      default: ;
    endcase
  end

  // A load in the bank whose destination feeds the incoming instruction costs one bubble.
  assign hazard = bank_q.valid & bank_q.mem_read & (bank_q.rd != '0) & bus.in_valid &
                  ((bank_q.rd == rs1_i) | (bank_q.rd == rs2_i) | (bank_q.rd == rd_i));

  always_comb begin
    bank_d = bank_q;
    if (bus.flush_in)                                   bank_d = '0;
    else if (bus.stall_in)                              bank_d = bank_q;
    else if (hazard || bank_q.jump || !bus.in_valid)    bank_d = '0;
    else                                                bank_d = dec;
  end

  always_comb begin
    rf_d = rf_q;
    if (bus.rf_write && (bus.loadAddr != '0)) rf_d[bus.loadAddr] = bus.loadData;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bank_q <= '0;
      rf_q   <= '0;
    end else begin
      bank_q <= bank_d;
      rf_q   <= rf_d;
    end
  end

  assign bus.stall_out = bus.stall_in | hazard;
  assign bus.out_valid = bank_q.valid;
  assign bus.RegWrite  = bank_q.reg_write;
  assign bus.ALUSrc    = bank_q.alu_src;
  assign bus.MemWrite  = bank_q.mem_write;
  assign bus.MemRead   = bank_q.mem_read;
  assign bus.RegStore  = bank_q.reg_store;
  assign bus.ALUOp     = bank_q.alu_op;
  assign bus.OPCP2     = bank_q.opcp2;
  assign bus.Arg1      = bank_q.arg1;
  assign bus.Arg2      = bank_q.arg2;
  assign bus.Arg3      = bank_q.arg3;
  assign bus.Imm       = bank_q.imm;
  assign bus.new_pc    = bank_q.new_pc;
  assign bus.Rs1       = bank_q.rs1;
  assign bus.Rs2       = bank_q.rs2;
  assign bus.Rd        = bank_q.rd;
  assign bus.jump      = bank_q.jump;
endmodule

// File: tb/tb_decode_stage_pipe.sv
// Bench for decode_stage_pipe: directed steps followed by random traffic, all checked against
// a behavioural model of the instruction set, register file and pipeline handshakes.
module tb_decode_stage_pipe;
  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  decode_stage_pipe_if #(.XLEN(16), .REG_AW(4)) bus ();
  decode_stage_pipe #(.XLEN(16), .REG_AW(4)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

`ifdef DECODE_FWD_EN
  localparam logic [15:0] SAME_CYCLE_EXP = 16'hBEEF;
`else
  localparam logic [15:0] SAME_CYCLE_EXP = 16'h1234;
`endif

  typedef struct {
    logic        v, rw, alusrc, mw, mr, rst, jmp;
    logic [2:0]  aluop;
    logic [15:0] opcp2, a1, a2, a3, imm, npc;
    logic [3:0]  rs1, rs2, rd;
  } exp_t;

  exp_t        exp_q;
  logic [15:0] mregs [16];
  logic        known;
  logic        stall_seen;

  function automatic exp_t zero_bank();
    exp_t e;
    e = '{default: '0};
    return e;
  endfunction

  function automatic void chk(string tag, logic [15:0] obs, logic [15:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endfunction

  function automatic logic [15:0] mread(int idx);
    if (idx == 0) return 16'h0;
`ifdef DECODE_FWD_EN
    if (bus.rf_write && int'(bus.loadAddr) == idx) return bus.loadData;
`endif
    return mregs[idx];
  endfunction

  // Reference decode of the instruction currently on the inputs.
  function automatic exp_t mdecode();
    exp_t e;
    int op, i4, i8;
    e  = zero_bank();
    op = int'(bus.ir_in[15:12]);
    i4 = bus.ir_in[3] ? int'(bus.ir_in[3:0]) - 16  : int'(bus.ir_in[3:0]);
    i8 = bus.ir_in[7] ? int'(bus.ir_in[7:0]) - 256 : int'(bus.ir_in[7:0]);
    e.v = 1'b1;
    e.rd = bus.ir_in[11:8]; e.rs1 = bus.ir_in[7:4]; e.rs2 = bus.ir_in[3:0];
    e.a1 = mread(int'(e.rs1)); e.a2 = mread(int'(e.rs2)); e.a3 = mread(int'(e.rd));
    e.opcp2 = bus.IPCP2;
    e.npc   = bus.pc_in;
    if (op >= 1 && op <= 7) begin
      e.rw = 1'b1; e.aluop = 3'(op);
    end else if (op == 8) begin
      e.rw = 1'b1; e.alusrc = 1'b1; e.aluop = 3'd1; e.imm = 16'(i4);
    end else if (op == 9) begin
      e.rw = 1'b1; e.mr = 1'b1; e.alusrc = 1'b1; e.aluop = 3'd1; e.imm = 16'(i4);
    end else if (op == 10) begin
      e.mw = 1'b1; e.rst = 1'b1; e.alusrc = 1'b1; e.aluop = 3'd1; e.imm = 16'(i4);
    end else if (op == 11 || op == 12) begin
      if ((e.a3 == e.a1) == (op == 11)) begin
        e.jmp = 1'b1; e.npc = 16'(int'(bus.pc_in) + 2 * i4);
      end
    end else if (op == 13) begin
      e.rw = 1'b1; e.jmp = 1'b1; e.npc = 16'(int'(bus.pc_in) + 2 * i8);
    end else if (op == 14) begin
      e.jmp = 1'b1; e.npc = e.a1;
    end else if (op == 15) begin
      e.rw = 1'b1; e.alusrc = 1'b1; e.imm = int'(bus.ir_in[7:0]) * 256;
    end
    return e;
  endfunction

  task automatic compare_all(string t);
    chk({t, ".out_valid"}, 16'(bus.out_valid), 16'(exp_q.v));
    chk({t, ".RegWrite"},  16'(bus.RegWrite),  16'(exp_q.rw));
    chk({t, ".ALUSrc"},    16'(bus.ALUSrc),    16'(exp_q.alusrc));
    chk({t, ".MemWrite"},  16'(bus.MemWrite),  16'(exp_q.mw));
    chk({t, ".MemRead"},   16'(bus.MemRead),   16'(exp_q.mr));
    chk({t, ".RegStore"},  16'(bus.RegStore),  16'(exp_q.rst));
    chk({t, ".ALUOp"},     16'(bus.ALUOp),     16'(exp_q.aluop));
    chk({t, ".OPCP2"},     bus.OPCP2,          exp_q.opcp2);
    chk({t, ".Arg1"},      bus.Arg1,           exp_q.a1);
    chk({t, ".Arg2"},      bus.Arg2,           exp_q.a2);
    chk({t, ".Arg3"},      bus.Arg3,           exp_q.a3);
    chk({t, ".Imm"},       bus.Imm,            exp_q.imm);
    chk({t, ".new_pc"},    bus.new_pc,         exp_q.npc);
    chk({t, ".Rs1"},       16'(bus.Rs1),       16'(exp_q.rs1));
    chk({t, ".Rs2"},       16'(bus.Rs2),       16'(exp_q.rs2));
    chk({t, ".Rd"},        16'(bus.Rd),        16'(exp_q.rd));
    chk({t, ".jump"},      16'(bus.jump),      16'(exp_q.jmp));
  endtask

  // One clock: check the combinational stall, advance the model, compare the bank.
  task automatic cycle(string t);
    exp_t nxt;
    logic hz, exp_stall;
    #1;
    hz = exp_q.v && exp_q.mr && (exp_q.rd != 4'd0) && bus.in_valid &&
         (exp_q.rd == bus.ir_in[7:4] || exp_q.rd == bus.ir_in[3:0] || exp_q.rd == bus.ir_in[11:8]);
    exp_stall  = bus.stall_in | hz;
    stall_seen = bus.stall_out;
    if (known) chk({t, ".stall_out"}, 16'(stall_seen), 16'(exp_stall));
    if (reset || bus.flush_in)                  nxt = zero_bank();
    else if (bus.stall_in)                      nxt = exp_q;
    else if (hz || exp_q.jmp || !bus.in_valid)  nxt = zero_bank();
    else                                        nxt = mdecode();
    @(posedge clk);
    if (reset) foreach (mregs[i]) mregs[i] = 16'h0;
    else if (bus.rf_write && bus.loadAddr != 4'd0) mregs[bus.loadAddr] = bus.loadData;
    exp_q = nxt;
    known = 1'b1;
    #1;
    compare_all(t);
  endtask

  task automatic idle();
    bus.in_valid = 1'b0; bus.pc_in = 16'h0; bus.IPCP2 = 16'h0; bus.ir_in = 16'h0;
    bus.stall_in = 1'b0; bus.flush_in = 1'b0; bus.rf_write = 1'b0;
    bus.loadAddr = 4'd0; bus.loadData = 16'h0;
  endtask

  task automatic rand_inputs();
    bus.in_valid = ($urandom_range(99) < 85);
    bus.stall_in = ($urandom_range(99) < 10);
    bus.flush_in = ($urandom_range(99) < 5);
    bus.rf_write = 1'($urandom_range(1));
    bus.loadAddr = 4'($urandom_range(15));
    bus.loadData = 16'($urandom);
    bus.pc_in    = 16'($urandom);
    bus.IPCP2    = bus.pc_in + 16'd2;
    bus.ir_in    = 16'($urandom);
    if ($urandom_range(1) == 1) bus.ir_in[11:0] = bus.ir_in[11:0] & 12'h333;
    if ($urandom_range(3) == 0) bus.ir_in[15:12] = 4'h9;
  endtask

  task automatic write_reg(int idx, logic [15:0] val);
    idle();
    bus.rf_write = 1'b1; bus.loadAddr = 4'(idx); bus.loadData = val;
    cycle("wr");
  endtask

  task automatic issue(logic [15:0] ir, logic [15:0] pc, string t);
    idle();
    bus.in_valid = 1'b1; bus.ir_in = ir; bus.pc_in = pc; bus.IPCP2 = pc + 16'd2;
    cycle(t);
  endtask

  initial begin
    exp_q = zero_bank();
    known = 1'b0;
    foreach (mregs[i]) mregs[i] = 16'h0;
    idle();
    reset = 1'b1;
    cycle("rst0");
    cycle("rst1");
    chk("rst.out_valid", 16'(bus.out_valid), 16'h0);
    chk("rst.new_pc", bus.new_pc, 16'h0);
    chk("rst.stall_out", 16'(bus.stall_out), 16'h0);
    for (int n = 0; n < 4; n++) begin
      rand_inputs();
      bus.stall_in = 1'b0;
      cycle("rst_rand");
      chk("rst_rand.Arg1", bus.Arg1, 16'h0);
    end

    reset = 1'b0;
    write_reg(3, 16'h1234);
    issue(16'h1130, 16'h0040, "add");
    chk("add.Arg1", bus.Arg1, 16'h1234);
    chk("add.Arg2", bus.Arg2, 16'h0);
    chk("add.RegWrite", 16'(bus.RegWrite), 16'h1);
    chk("add.ALUOp", 16'(bus.ALUOp), 16'h1);
    chk("add.Rd", 16'(bus.Rd), 16'h1);

    idle();
    bus.rf_write = 1'b1; bus.loadAddr = 4'd3; bus.loadData = 16'hBEEF;
    bus.in_valid = 1'b1; bus.ir_in = 16'h1130;
    cycle("same_cycle");
    chk("same_cycle.Arg1", bus.Arg1, SAME_CYCLE_EXP);

    idle();
    bus.in_valid = 1'b1; bus.ir_in = 16'h0000; bus.pc_in = 16'd198; bus.IPCP2 = 16'd200;
    cycle("nop");
    chk("nop.OPCP2", bus.OPCP2, 16'd200);
    chk("nop.new_pc", bus.new_pc, 16'd198);
    chk("nop.out_valid", 16'(bus.out_valid), 16'h1);
    write_reg(0, 16'hFFFF);
    issue(16'h2000, 16'h0050, "r0");
    chk("r0.Arg1", bus.Arg1, 16'h0);
    chk("r0.Arg3", bus.Arg3, 16'h0);

    write_reg(1, 16'd5);
    write_reg(2, 16'd5);
    issue(16'hB12E, 16'h0010, "beq_t");
    chk("beq_t.jump", 16'(bus.jump), 16'h1);
    chk("beq_t.new_pc", bus.new_pc, 16'h000C);
    issue(16'h1130, 16'h0012, "squash");
    chk("squash.out_valid", 16'(bus.out_valid), 16'h0);
    write_reg(2, 16'd6);
    issue(16'hB12E, 16'h0010, "beq_nt");
    chk("beq_nt.jump", 16'(bus.jump), 16'h0);
    chk("beq_nt.new_pc", bus.new_pc, 16'h0010);
    issue(16'hC12E, 16'h0010, "bne_t");
    chk("bne_t.jump", 16'(bus.jump), 16'h1);
    issue(16'h1130, 16'h0012, "squash2");
    issue(16'hD302, 16'hFFFE, "jal");
    chk("jal.new_pc", bus.new_pc, 16'h0002);
    chk("jal.jump", 16'(bus.jump), 16'h1);
    chk("jal.OPCP2", bus.OPCP2, 16'h0000);
    idle();
    cycle("post_jal");

    write_reg(4, 16'h0044);
    issue(16'h9450, 16'h0100, "lw");
    chk("lw.MemRead", 16'(bus.MemRead), 16'h1);
    issue(16'h1640, 16'h0102, "lu_stall");
    chk("lu_stall.stall_out", 16'(stall_seen), 16'h1);
    chk("lu_stall.out_valid", 16'(bus.out_valid), 16'h0);
    issue(16'h1640, 16'h0102, "lu_accept");
    chk("lu_accept.stall_out", 16'(stall_seen), 16'h0);
    chk("lu_accept.out_valid", 16'(bus.out_valid), 16'h1);
    chk("lu_accept.Arg1", bus.Arg1, 16'h0044);

    issue(16'h1130, 16'h02FE, "pre_stall");
    for (int n = 0; n < 3; n++) begin
      rand_inputs();
      bus.stall_in = 1'b1; bus.flush_in = 1'b0;
      cycle("stall");
      chk("stall.OPCP2", bus.OPCP2, 16'h0300);
      chk("stall.stall_out", 16'(stall_seen), 16'h1);
    end
    bus.stall_in = 1'b1; bus.flush_in = 1'b1; bus.in_valid = 1'b1;
    cycle("flush_stall");
    chk("flush_stall.out_valid", 16'(bus.out_valid), 16'h0);
    chk("flush_stall.new_pc", bus.new_pc, 16'h0);

    issue(16'h1130, 16'h0400, "pre_rst");
    bus.stall_in = 1'b1;
    reset = 1'b1;
    cycle("rst_stall");
    chk("rst_stall.out_valid", 16'(bus.out_valid), 16'h0);
    chk("rst_stall.OPCP2", bus.OPCP2, 16'h0);
    reset = 1'b0;
    issue(16'h1130, 16'h0410, "after_rst");
    chk("after_rst.Arg1", bus.Arg1, 16'h0);

    for (int n = 0; n < 400; n++) begin
      rand_inputs();
      reset = ($urandom_range(99) < 2);
      cycle("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
